sha256_w_expander_param: RTL and testbench
==========================================

# sha256_w_expander_param

Parametrised SHA-256 message-schedule expander for the double-SHA256 mining pipeline. It accepts one 512-bit message block, or a compact padded tail whose constant words are inserted internally. It streams the full 64-word schedule W0..W63 to the compression rounds, emitting WORDS_PER_CYCLE words per beat. Output is handshaked, so a stalled round core holds the schedule in place.

## Interface
- WORDS_PER_CYCLE, 1: words emitted and generated per beat; legal values 1, 2, 4.
- PAD_MODE, 0: block source.
  - 0 = full block.
  - 1 = 80-byte-header second chunk: W0..W3 from input, W4=0x80000000, W5..W14=0, W15=0x00000280.
  - 2 = double-hash second pass: W0..W7 from input, W8=0x80000000, W9..W14=0, W15=0x00000100.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous flush to IDLE.
- in_valid  in  1  block_in valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- block_in  in  512  message words, MSB-first.
  - Mode 0: [511:480]=W0 … [31:0]=W15.
  - Mode 1: [127:0]=W0..W3.
  - Mode 2: [255:0]=W0..W7.
  - Unused bits are ignored.
- w_valid  out  1  w_out valid.
- w_ready  in  1  downstream accepts beat.
- w_out  out  32*WORDS_PER_CYCLE  schedule words; lowest index in the MSBs.
- w_idx  out  6  index of the word in the MSBs of w_out.
- w_last  out  1  current beat holds W63.

## Operation
- Window: 16×32-bit register array win[0..15], where win[0] is the oldest word. w_out = {win[0], …, win[WPC-1]}, driven directly from registers.
- States:
  - IDLE: in_ready=1, w_valid=0.
  - RUN: w_valid=1.
- IDLE → RUN on input handshake. The window is loaded per PAD_MODE, w_idx=0.
- RUN, beat handshake (w_valid && w_ready):
  - The window shifts left by WPC.
  - WPC new words are appended at win[16-WPC..15].
  - w_idx += WPC.
- New word rule, t = 16..63: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Chaining within one beat: for WPC=4, new word j uses new words j-2 of the same beat combinationally. The operand chain is σ1 → 4-input add, depth ≤ 2 expansions.
- Words generated beyond W63 are don't-care and never presented.
- Final beat (w_idx == 64-WPC, w_last=1):
  - On handshake, go to IDLE.
  - in_ready is also asserted combinationally in this cycle (in_ready = IDLE || (w_last && w_ready)).
  - A simultaneous input handshake reloads the window and stays in RUN with w_idx=0, giving zero bubbles between blocks.
- Backpressure: w_ready=0 holds window, w_out, w_idx and w_valid unchanged.
- abort in any state: next state IDLE, w_valid=0, w_idx=0. Window contents are don't-care. abort overrides a same-cycle input handshake, and that block is dropped.

## Timing
- Reset values:
  - Outputs: w_valid=0, w_last=0, w_idx=0, w_out=0.
  - State: IDLE, with in_ready=1 once RST deasserts.
  - Window: all zeros.
- Reset mid-block: immediate return to reset values, and the block is lost.
- Latency: input handshake at edge N gives w_valid=1 with W0.. from edge N (visible in cycle N+1).
- Throughput: 64/WPC beats per block (64, 32, 16) with w_ready tied high. Back-to-back blocks have no idle cycle.
- All outputs except in_ready are registered.

## Test plan
- Mode 0, WPC=1, "abc" padded block (W0=0x61626380, W15=0x00000018, others 0), w_ready=1:
  - W16=0x61626380, W17=0x000F0000.
  - 64 beats, w_last on w_idx=63.
  - W0..W63 match the software model.
- Mode 2, WPC=4, block_in=0 → first beat {0,0,0,0}; beat w_idx=16 has W16=0x00000000, W17=0x00A00000; 16 beats total.
- Mode 1, WPC=2, block_in=0 → W4=0x80000000, W15=0x00000280, W17=0x01100000; 32 beats.
- Random w_ready toggling, WPC=2, random blocks → w_out/w_idx stable while stalled; stream equals the model.
- Back-to-back: second in_valid held high during first block → accepted on first block's w_last beat; next cycle shows w_idx=0 with the new W0, no gap.
- abort asserted at w_idx=20 → w_valid=0 next cycle, in_ready=1. RST asserted mid-block → outputs at reset values asynchronously; the next block streams correctly.

Source files
------------

// File: rtl/sha256_w_expander_param.sv
// sha256_w_expander_param
// SHA-256 message-schedule expander. Loads a 512-bit block, or a compact padded
// tail with its constant words inserted here, then streams W0..W63
// WORDS_PER_CYCLE words per beat over a valid/ready handshake. The schedule is
// kept in a 16-word sliding window. win[0] is the oldest word and is presented
// in the MSBs of w_out.
module sha256_w_expander_param #(
   parameter int WORDS_PER_CYCLE = 1,   // 1, 2 or 4
   parameter int PAD_MODE        = 0    // 0 full block, 1 header tail, 2 second pass
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           abort,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [511:0]                   block_in,
   output logic                           w_valid,
   input  logic                           w_ready,
   output logic [32*WORDS_PER_CYCLE-1:0]  w_out,
   output logic [5:0]                     w_idx,
   output logic                           w_last
);

   localparam int         WPC      = WORDS_PER_CYCLE;
   localparam logic [5:0] IDX_STEP = 6'(WPC);
   localparam logic [5:0] LAST_IDX = 6'(64 - WPC);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        last_q, last_d;
   logic        load_en, shift_en;

   logic [31:0] win_q     [16];
   logic [31:0] win_load  [16];
   logic [31:0] win_shift [16];
   logic [31:0] ext       [16+WPC];

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Initial window contents for the configured block source.
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      for (int i = 0; i < 16; i++) win_load[i] = '0;
      case (PAD_MODE)
         1: begin
            for (int i = 0; i < 4; i++) win_load[i] = block_in[127-32*i -: 32];
            win_load[4]  = 32'h8000_0000;
            win_load[15] = 32'h0000_0280;   // 640-bit message length
         end
         2: begin
            for (int i = 0; i < 8; i++) win_load[i] = block_in[255-32*i -: 32];
            win_load[8]  = 32'h8000_0000;
            win_load[15] = 32'h0000_0100;   // 256-bit message length
         end
         default: begin
            for (int i = 0; i < 16; i++) win_load[i] = block_in[511-32*i -: 32];
         end
      endcase
   end

   // Generate WPC new words; word j reuses new word j-2 of the same beat.
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = win_q[i];
      for (int j = 0; j < WPC; j++) begin
         ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
      end
      for (int i = 0; i < 16; i++) win_shift[i] = ext[i+WPC];
   end

   // Next-state logic: abort beats a reload, a reload beats a plain beat.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      load_en  = 1'b0;
      shift_en = 1'b0;
      if (abort) begin
         state_d = IDLE;
         idx_d   = '0;
         last_d  = 1'b0;
      end else if (in_valid && in_ready) begin
         // Either idle, or the final beat is completing this cycle.
         load_en = 1'b1;
         state_d = RUN;
         idx_d   = '0;
         last_d  = 1'b0;
      end else if (state_q == RUN && w_ready) begin
         if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
         end else begin
            shift_en = 1'b1;
            idx_d    = idx_q + IDX_STEP;
            last_d   = ((idx_q + IDX_STEP) == LAST_IDX);
         end
      end
   end

   // State, beat index and last-beat flag registers.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   // Sliding window: load a block or shift by one beat.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: the window is reset because w_out is driven straight from it and
      // must read zero out of reset.
      if (RST) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else if (load_en) begin
         win_q <= win_load;
      end else if (shift_en) begin
         win_q <= win_shift;
      end
   end

   // A new block may be taken while the final beat is being accepted.
   assign in_ready = (state_q == IDLE) || (last_q && w_ready);
   assign w_valid  = (state_q == RUN);
   assign w_idx    = idx_q;
   assign w_last   = last_q;

   for (genvar k = 0; k < WPC; k++) begin : g_out
      assign w_out[32*(WPC-k)-1 -: 32] = win_q[k];
   end

endmodule

// File: tb/tb_sha256_w_expander_param.sv
// Testbench for sha256_w_expander_param: four configurations driven in turn,
// each compared against a plain-array SHA-256 schedule model.
module tb_sha256_w_expander_param;

   logic         clk = 1'b0;
   logic         rst;
   logic         abort;
   logic [511:0] block_in;
   logic         w_ready;

   logic         iv0, iv1, iv2, iv3;
   logic         ir0, ir1, ir2, ir3;
   logic         wv0, wv1, wv2, wv3;
   logic         wl0, wl1, wl2, wl3;
   logic [5:0]   idx0, idx1, idx2, idx3;
   logic [31:0]  wo0;
   logic [127:0] wo1;
   logic [63:0]  wo2, wo3;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0]  ref_w [64];
   logic [127:0] cap   [64];

   always #5 clk = ~clk;

   sha256_w_expander_param #(.WORDS_PER_CYCLE(1), .PAD_MODE(0)) u0 (
      .CLK(clk), .RST(rst), .abort(abort), .in_valid(iv0), .in_ready(ir0),
      .block_in(block_in), .w_valid(wv0), .w_ready(w_ready), .w_out(wo0),
      .w_idx(idx0), .w_last(wl0));

   sha256_w_expander_param #(.WORDS_PER_CYCLE(4), .PAD_MODE(2)) u1 (
      .CLK(clk), .RST(rst), .abort(abort), .in_valid(iv1), .in_ready(ir1),
      .block_in(block_in), .w_valid(wv1), .w_ready(w_ready), .w_out(wo1),
      .w_idx(idx1), .w_last(wl1));

   sha256_w_expander_param #(.WORDS_PER_CYCLE(2), .PAD_MODE(1)) u2 (
      .CLK(clk), .RST(rst), .abort(abort), .in_valid(iv2), .in_ready(ir2),
      .block_in(block_in), .w_valid(wv2), .w_ready(w_ready), .w_out(wo2),
      .w_idx(idx2), .w_last(wl2));

   sha256_w_expander_param #(.WORDS_PER_CYCLE(2), .PAD_MODE(0)) u3 (
      .CLK(clk), .RST(rst), .abort(abort), .in_valid(iv3), .in_ready(ir3),
      .block_in(block_in), .w_valid(wv3), .w_ready(w_ready), .w_out(wo3),
      .w_idx(idx3), .w_last(wl3));

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Full 64-word schedule straight from the SHA-256 definition.
   task automatic build_ref(input logic [511:0] blk, input int mode);
      for (int i = 0; i < 64; i++) ref_w[i] = '0;
      if (mode == 1) begin
         for (int i = 0; i < 4; i++) ref_w[i] = blk[127-32*i -: 32];
         ref_w[4]  = 32'h8000_0000;
         ref_w[15] = 32'h0000_0280;
      end else if (mode == 2) begin
         for (int i = 0; i < 8; i++) ref_w[i] = blk[255-32*i -: 32];
         ref_w[8]  = 32'h8000_0000;
         ref_w[15] = 32'h0000_0100;
      end else begin
         for (int i = 0; i < 16; i++) ref_w[i] = blk[511-32*i -: 32];
      end
      for (int t = 16; t < 64; t++) begin
         ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                  + ref_w[t-7]
                  + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                  + ref_w[t-16];
      end
   endtask

   // Expected {valid, last, idx, words} of beat b.
   function automatic logic [159:0] exp_beat(input int wpc, input int b);
      logic [127:0] d = '0;
      for (int k = 0; k < wpc; k++) d = (d << 32) | 128'(ref_w[b*wpc + k]);
      return {24'b0, 1'b1, (b == 64/wpc - 1), 6'(b*wpc), d};
   endfunction

   function automatic logic [159:0] obs_u(input int n);
      case (n)
         0:       return {24'b0, wv0, wl0, idx0, 128'(wo0)};
         1:       return {24'b0, wv1, wl1, idx1, wo1};
         2:       return {24'b0, wv2, wl2, idx2, 128'(wo2)};
         default: return {24'b0, wv3, wl3, idx3, 128'(wo3)};
      endcase
   endfunction

   function automatic logic ir_u(input int n);
      case (n)
         0:       return ir0;
         1:       return ir1;
         2:       return ir2;
         default: return ir3;
      endcase
   endfunction

   task automatic set_iv(input int n, input logic v);
      case (n)
         0:       iv0 = v;
         1:       iv1 = v;
         2:       iv2 = v;
         default: iv3 = v;
      endcase
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b = '0;
      for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
      return b;
   endfunction

   // One input handshake on instance n (called at a negedge).
   task automatic start(input int n, input logic [511:0] blk, input string tag);
      check({tag, "_in_ready"}, 160'(ir_u(n)), 160'(1));
      block_in = blk;
      set_iv(n, 1'b1);
      @(negedge clk);
      set_iv(n, 1'b0);
   endtask

   // Check every beat of one block; stalled cycles must repeat the same beat.
   task automatic stream(input int n, input int wpc, input string tag, input bit rand_stall);
      int beats  = 64 / wpc;
      int pos    = 0;
      int cycles = 0;
      while (pos < beats && cycles < 1000) begin
         cap[pos] = obs_u(n)[127:0];
         check($sformatf("%s_b%0d", tag, pos), obs_u(n), exp_beat(wpc, pos));
         w_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (w_ready) pos++;
         @(negedge clk);
         cycles++;
      end
      w_ready = 1'b1;
      if (cycles >= 1000) begin
         n_checks++;
         $error("FAIL %s_timeout observed=%0d beats expected=%0d beats", tag, pos, beats);
      end
      check({tag, "_idle"}, 160'(obs_u(n)[135:128]), 160'(0));
   endtask

   logic [511:0] blk_a, blk_b;

   initial begin
      rst = 1'b1; abort = 1'b0; block_in = '0; w_ready = 1'b1;
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         check($sformatf("reset_out_u%0d", n), obs_u(n), '0);
         check($sformatf("reset_in_ready_u%0d", n), 160'(ir_u(n)), 160'(1));
      end

      // Mode 0, one word per beat, "abc".
      blk_a = {32'h6162_6380, 448'b0, 32'h0000_0018};
      build_ref(blk_a, 0);
      start(0, blk_a, "abc");
      stream(0, 1, "abc", 1'b0);
      check("abc_W16", 160'(cap[16][31:0]), 160'(32'h6162_6380));
      check("abc_W17", 160'(cap[17][31:0]), 160'(32'h000F_0000));

      // Mode 2, four words per beat, zero input.
      build_ref('0, 2);
      start(1, '0, "m2");
      stream(1, 4, "m2", 1'b0);
      check("m2_first_beat", 160'(cap[0]), 160'(0));
      check("m2_W16", 160'(cap[4][127:96]), 160'(0));
      check("m2_W17", 160'(cap[4][95:64]), 160'(32'h00A0_0000));

      // Mode 1, two words per beat, zero input.
      build_ref('0, 1);
      start(2, '0, "m1");
      stream(2, 2, "m1", 1'b0);
      check("m1_W4", 160'(cap[2][63:32]), 160'(32'h8000_0000));
      check("m1_W15", 160'(cap[7][31:0]), 160'(32'h0000_0280));
      check("m1_W17", 160'(cap[8][31:0]), 160'(32'h0110_0000));

      // Random blocks with random backpressure.
      for (int r = 0; r < 2; r++) begin
         blk_a = rand_blk();
         build_ref(blk_a, 0);
         start(3, blk_a, "rnd");
         stream(3, 2, $sformatf("rnd%0d", r), 1'b1);
      end

      // Back-to-back: second block waits on in_valid through the first.
      blk_a = rand_blk();
      blk_b = rand_blk();
      build_ref(blk_a, 0);
      block_in = blk_a;
      iv3 = 1'b1;
      @(negedge clk);
      block_in = blk_b;
      for (int b = 0; b < 32; b++) begin
         check($sformatf("b2b_A_b%0d", b), obs_u(3), exp_beat(2, b));
         if (b == 5)  check("b2b_busy_in_ready", 160'(ir3), 160'(0));
         if (b == 31) check("b2b_last_in_ready", 160'(ir3), 160'(1));
         @(negedge clk);
      end
      iv3 = 1'b0;
      build_ref(blk_b, 0);
      stream(3, 2, "b2b_B", 1'b0);

      // Abort at w_idx 20.
      blk_a = rand_blk();
      build_ref(blk_a, 0);
      start(3, blk_a, "abort");
      for (int b = 0; b <= 10; b++) begin
         check($sformatf("abort_b%0d", b), obs_u(3), exp_beat(2, b));
         if (b == 10) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      check("abort_out", 160'(obs_u(3)[135:128]), 160'(0));
      check("abort_in_ready", 160'(ir3), 160'(1));

      // Abort drops a same-cycle block.
      block_in = rand_blk();
      iv3 = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      iv3 = 1'b0;
      abort = 1'b0;
      check("abort_drop_valid", 160'(wv3), 160'(0));
      check("abort_drop_in_ready", 160'(ir3), 160'(1));

      // Asynchronous reset mid-block, then a clean block.
      blk_a = rand_blk();
      build_ref(blk_a, 0);
      start(3, blk_a, "rst_mid");
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("rst_mid_out", obs_u(3), '0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_in_ready", 160'(ir3), 160'(1));
      blk_a = rand_blk();
      build_ref(blk_a, 0);
      start(3, blk_a, "post_rst");
      stream(3, 2, "post_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
